// File: rtl/ttpu_addr_pkg.sv
// ttpu_addr_pkg: shared widths, address type and FSM states for the TTPU window address generator.
package ttpu_addr_pkg;
  localparam int AG_N_UNITS = 16;
  localparam int AG_ADDR_W = 16;
  localparam int AG_KDIM_W = 8;
  localparam int AG_TAP_W = 16;
  localparam int AG_DIL_MIN = 1;
  typedef logic [AG_ADDR_W-1:0] addr_t;
  typedef enum logic [1:0] {AG_IDLE, AG_LOAD, AG_RUN, AG_DONE} ag_state_e;
endpackage

// File: rtl/conv_tap_counter.sv
// conv_tap_counter: row-major kx/ky walk of a dilated kernel window with a shared offset accumulator.
module conv_tap_counter
  import ttpu_addr_pkg::*;
#(
  parameter int ADDR_W = AG_ADDR_W,
  parameter int KDIM_W = AG_KDIM_W,
  parameter int TAP_W = AG_TAP_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_clr,
  input  logic              i_adv,
  input  logic [KDIM_W-1:0] i_kw,
  input  logic [KDIM_W-1:0] i_kh,
  input  logic [7:0]        i_dil,
  input  logic [ADDR_W-1:0] i_width,
  output logic [ADDR_W-1:0] o_offset,
  output logic [TAP_W-1:0]  o_tap_idx,
  output logic              o_last_tap
);
  logic [KDIM_W-1:0] r_kx, r_ky;
  logic [ADDR_W-1:0] r_offset, w_dil, w_row_step;
  logic [TAP_W-1:0] r_tap;
  logic w_row_end;
  assign w_dil = ADDR_W'(i_dil);
  // jump from the last tap of a row back to kx=0 of the next dilated row
  assign w_row_step = i_width * w_dil - (ADDR_W'(i_kw) - ADDR_W'(1)) * w_dil;
  assign w_row_end = r_kx == i_kw - KDIM_W'(1);
  assign o_last_tap = w_row_end && r_ky == i_kh - KDIM_W'(1);
  assign o_offset = r_offset;
  assign o_tap_idx = r_tap;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_kx <= '0;
      r_ky <= '0;
      r_offset <= '0;
      r_tap <= '0;
    end else if (i_clr) begin
      r_kx <= '0;
      r_ky <= '0;
      r_offset <= '0;
      r_tap <= '0;
    end else if (i_adv) begin
      r_kx <= w_row_end ? '0 : r_kx + KDIM_W'(1);
      r_ky <= w_row_end ? r_ky + KDIM_W'(1) : r_ky;
      r_offset <= r_offset + (w_row_end ? w_row_step : w_dil);
      r_tap <= r_tap + TAP_W'(1);
    end
  end
endmodule

// File: rtl/conv_window_addr_gen.sv
// conv_window_addr_gen: per-lane 2D convolution window address stream over valid/ready.
// Optional TTPU_AG_BOUNDS_EN adds img_size capture and per-lane out-of-bounds flags.
module conv_window_addr_gen
  import ttpu_addr_pkg::*;
#(
  parameter int N_UNITS = AG_N_UNITS,
  parameter int ADDR_W = AG_ADDR_W,
  parameter int KDIM_W = AG_KDIM_W,
  parameter int TAP_W = AG_TAP_W
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        i_start,
  input  logic [ADDR_W-1:0]           i_start_addr,
  input  logic [KDIM_W-1:0]           i_kernel_w,
  input  logic [KDIM_W-1:0]           i_kernel_h,
  input  logic [7:0]                  i_dilation,
  input  logic [7:0]                  i_stride,
  input  logic [ADDR_W-1:0]           i_width,
  input  logic [N_UNITS-1:0]          i_active_units,
  input  logic                        i_addr_ready,
`ifdef TTPU_AG_BOUNDS_EN
  input  logic [ADDR_W-1:0]           i_img_size,
  output logic [N_UNITS-1:0]          o_oob,
`endif
  output logic                        o_busy,
  output logic                        o_done,
  output logic                        o_addr_valid,
  output logic [N_UNITS*ADDR_W-1:0]   o_addr_out,
  output logic [N_UNITS-1:0]          o_unit_en,
  output logic [TAP_W-1:0]            o_tap_idx,
  output logic                        o_last_tap
);
  localparam int LANE_W = N_UNITS > 1 ? $clog2(N_UNITS) : 1;
  ag_state_e r_state, w_next;
  logic [ADDR_W-1:0] r_next_base, r_width, w_offset;
  logic [ADDR_W-1:0] r_base [N_UNITS];
  logic [KDIM_W-1:0] r_kw, r_kh;
  logic [7:0] r_dil, r_stride;
  logic [N_UNITS-1:0] r_mask;
  logic [LANE_W-1:0] r_lane;
  logic w_load_end, w_run, w_adv, w_last;
  assign w_load_end = r_lane == LANE_W'(N_UNITS - 1);
  assign w_adv = w_run && i_addr_ready;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= AG_IDLE;
    else r_state <= w_next;
  end
  always_comb begin
    w_next = r_state;
    w_run = r_state == AG_RUN;
    o_busy = r_state == AG_LOAD || r_state == AG_RUN;
    o_done = r_state == AG_DONE;
    case (r_state)
      AG_IDLE: w_next = i_start ? AG_LOAD : AG_IDLE;
      AG_LOAD: w_next = w_load_end ? (|r_mask ? AG_RUN : AG_DONE) : AG_LOAD;
      AG_RUN:  w_next = w_adv && w_last ? AG_DONE : AG_RUN;
      default: w_next = AG_IDLE;
    endcase
  end
  assign o_addr_valid = w_run;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_next_base <= '0;
      r_width <= '0;
      r_kw <= '0;
      r_kh <= '0;
      r_dil <= '0;
      r_stride <= '0;
      r_mask <= '0;
      r_lane <= '0;
      for (int j = 0; j < N_UNITS; j++) r_base[j] <= '0;
    end else if (r_state == AG_IDLE && i_start) begin
      r_next_base <= i_start_addr;
      r_width <= i_width;
      r_kw <= i_kernel_w == '0 ? KDIM_W'(1) : i_kernel_w;
      r_kh <= i_kernel_h == '0 ? KDIM_W'(1) : i_kernel_h;
      r_dil <= i_dilation == '0 ? 8'(AG_DIL_MIN) : i_dilation;
      r_stride <= i_stride;
      r_mask <= i_active_units;
      r_lane <= '0;
    end else if (r_state == AG_LOAD) begin
      // active lanes are packed at stride spacing; inactive lanes consume no slot
      r_base[r_lane] <= r_mask[r_lane] ? r_next_base : '0;
      r_next_base <= r_mask[r_lane] ? r_next_base + ADDR_W'(r_stride) : r_next_base;
      r_lane <= r_lane + LANE_W'(1);
    end
  end
  conv_tap_counter #(.ADDR_W(ADDR_W), .KDIM_W(KDIM_W), .TAP_W(TAP_W)) u_tap (
    .clk(clk),
    .rst(rst),
    .i_clr(r_state == AG_LOAD),
    .i_adv(w_adv),
    .i_kw(r_kw),
    .i_kh(r_kh),
    .i_dil(r_dil),
    .i_width(r_width),
    .o_offset(w_offset),
    .o_tap_idx(o_tap_idx),
    .o_last_tap(w_last)
  );
  assign o_last_tap = w_run && w_last;
  assign o_unit_en = r_mask;
`ifdef TTPU_AG_BOUNDS_EN
  logic [ADDR_W-1:0] r_img_size;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_img_size <= '0;
    else if (r_state == AG_IDLE && i_start) r_img_size <= i_img_size;
  end
`endif
  for (genvar g = 0; g < N_UNITS; g++) begin : g_lane
    assign o_addr_out[g*ADDR_W +: ADDR_W] = w_run && r_mask[g] ? r_base[g] + w_offset : '0;
`ifdef TTPU_AG_BOUNDS_EN
    logic [ADDR_W:0] w_sum;
    // one extra bit so a sum that wraps past 2^ADDR_W still compares as out of bounds
    assign w_sum = {1'b0, r_base[g]} + {1'b0, w_offset};
    assign o_oob[g] = w_run && r_mask[g] && w_sum >= {1'b0, r_img_size};
`endif
  end
endmodule
